// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM states, bubble instruction and opcodes shared with the decoders
package fetch_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} fetchState_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  function automatic logic [31:0] incPc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with stall hold, flush and bubble (NOP) injection
// ports: clk/rst; stall holds, flush kills, load captures {instrIn, pcIn, pcIn+4};
//        instr/pc/pcPlus4/valid go to decode
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcIn,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        valid
);
  import fetch_pkg::*;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      instr <= NOP_INSTR;
      pc <= '0;
      pcPlus4 <= '0;
      valid <= 1'b0;
    end else if (flush || (!load && !stall)) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instrIn;
      pc <= pcIn;
      pcPlus4 <= incPc(pcIn);
      valid <= 1'b1;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC + single-outstanding instruction fetch feeding a stallable/flushable IF/ID register
// ports: pc_src/pc_target redirect; stall_d/flush_d from hazard logic;
//        imem_req/imem_addr/imem_rdata/imem_rvalid memory side; instr_d/pc_d/pc_plus4_d/valid_d to decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  input  logic        stall_d,
  input  logic        flush_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);
  import fetch_pkg::*;
  fetchState_t state, nextState;
  logic [31:0] pcF, bufInstr;
  logic kill, rsp, load;
  assign rsp = state == S_WAIT && imem_rvalid;
  // a redirect always wins, so the old-path instruction is never loaded
  assign load = !pc_src && !stall_d && ((rsp && !kill) || state == S_HOLD);
  assign imem_req = state == S_REQ;
  assign imem_addr = pcF;
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: nextState = S_REQ;
      S_REQ: nextState = S_WAIT;
      S_WAIT: nextState = !imem_rvalid ? S_WAIT : (kill || pc_src || !stall_d) ? S_REQ : S_HOLD;
      S_HOLD: nextState = (pc_src || !stall_d) ? S_REQ : S_HOLD;
      default: nextState = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      pcF <= RESET_PC;
      kill <= 1'b0;
      bufInstr <= NOP_INSTR;
    end else begin
      state <= nextState;
      pcF <= pc_src ? (pc_target & ~32'd3) : load ? incPc(pcF) : pcF;
      // a redirect with a read still in flight marks its response for dropping
      kill <= rsp ? 1'b0 : (pc_src && (state == S_REQ || state == S_WAIT)) ? 1'b1 : kill;
      if (rsp && !kill && !pc_src && stall_d) bufInstr <= imem_rdata;
    end
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) ifId (
    .clk(clk),
    .rst(rst),
    .stall(stall_d),
    .flush(flush_d),
    .load(load),
    .instrIn(state == S_HOLD ? bufInstr : imem_rdata),
    .pcIn(pcF),
    .instr(instr_d),
    .pc(pc_d),
    .pcPlus4(pc_plus4_d),
    .valid(valid_d)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized + directed check of fetch_stage against an in-order fetch stream model
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 1, pc_src = 0, stall_d = 0, flush_d = 0, imem_rvalid = 0;
  logic [31:0] pc_target = 0, imem_rdata = 0;
  logic imem_req, valid_d;
  logic [31:0] imem_addr, instr_d, pc_d, pc_plus4_d;
  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .pc_target(pc_target),
    .stall_d(stall_d), .flush_d(flush_d), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [31:0] expPc = 0, prevInstr = NOP, prevPc = 0, prevTarget = 0, pendAddr = 0;
  logic prevValid = 0, prevStall = 0, prevSrc = 0, prevFlush = 0, prevReq = 0, pending = 0;
  int cnt = 0, latMin = 1, latMax = 1, deliveries = 0;
  logic [31:0] reqLog[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] memData(input logic [31:0] a);
    return a == 0 ? 32'h00500093 : a == 4 ? 32'h00A00113 : (a * 32'h9E3779B1) ^ 32'h13;
  endfunction
  // the decode stage must see, in order, the instructions at RESET_PC, +4, ... restarting at each redirect target
  task automatic cycle(input logic s, input logic src, input logic [31:0] tgt, input logic fl);
    @(negedge clk);
    if (prevFlush) begin
      check("flush_valid", 32'(valid_d), 0);
      check("flush_instr", instr_d, NOP);
    end else if (prevStall) begin
      check("hold_instr", instr_d, prevInstr);
      check("hold_pc", pc_d, prevPc);
      check("hold_valid", 32'(valid_d), 32'(prevValid));
    end else if (prevSrc) check("redirect_bubble", 32'(valid_d), 0);
    else if (valid_d) begin
      check("pc_d", pc_d, expPc);
      check("instr_d", instr_d, memData(expPc));
      check("pc_plus4_d", pc_plus4_d, expPc + 32'd4);
      expPc += 32'd4;
      deliveries++;
    end else check("bubble_instr", instr_d, NOP);
    if (prevSrc) expPc = prevTarget & ~32'd3;
    imem_rvalid = 0;
    imem_rdata = $urandom;
    if (pending) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1;
        imem_rdata = memData(pendAddr);
        pending = 0;
      end
    end
    if (imem_req) begin
      check("one_outstanding", 32'(pending), 0);
      check("req_pulse", 32'(prevReq), 0);
      reqLog.push_back(imem_addr);
      pending = 1;
      pendAddr = imem_addr;
      cnt = $urandom_range(latMax, latMin);
    end
    prevInstr = instr_d; prevPc = pc_d; prevValid = valid_d; prevReq = imem_req;
    stall_d = s; pc_src = src; pc_target = tgt; flush_d = fl;
    prevStall = s; prevSrc = src; prevTarget = tgt; prevFlush = fl;
  endtask
  task automatic waitReq();
    prevReq = 0;
    for (int i = 0; i < 12 && !prevReq; i++) cycle(0, 0, 0, 0);
    check("req_seen", 32'(prevReq), 1);
  endtask
  task automatic checkResetOutputs(input string tag);
    check({tag, "_valid"}, 32'(valid_d), 0);
    check({tag, "_instr"}, instr_d, NOP);
    check({tag, "_pc"}, pc_d, 0);
    check({tag, "_pc4"}, pc_plus4_d, 0);
    check({tag, "_req"}, 32'(imem_req), 0);
    check({tag, "_addr"}, imem_addr, 0);
  endtask
  initial begin
    int d0, r0;
    #12 checkResetOutputs("reset");
    @(negedge clk) rst = 0;
    for (int i = 0; i < 20 && deliveries == 0; i++) cycle(0, 0, 0, 0);
    check("first_fetch_seen", 32'(deliveries > 0), 1);
    d0 = deliveries;
    repeat (20) cycle(0, 0, 0, 0);
    check("throughput", 32'(deliveries - d0), 10);
    if (reqLog.size() >= 2) begin
      check("req_addr0", reqLog[0], 0);
      check("req_addr1", reqLog[1], 4);
    end else check("req_log_size", 32'(reqLog.size()), 2);
    latMin = 3; latMax = 3;
    d0 = deliveries;
    repeat (24) cycle(0, 0, 0, 0);
    check("slow_progress", 32'(deliveries - d0 >= 5), 1);
    latMin = 2; latMax = 2;
    waitReq();
    repeat (4) cycle(1, 0, 0, 0);
    d0 = deliveries;
    repeat (2) cycle(0, 0, 0, 0);
    check("skid_release", 32'(deliveries - d0), 1);
    repeat (4) cycle(0, 0, 0, 0);
    latMin = 3; latMax = 3;
    waitReq();
    r0 = reqLog.size();
    cycle(0, 1, 32'h0000_0103, 1);
    repeat (12) cycle(0, 0, 0, 0);
    if (reqLog.size() > r0) check("redirect_addr", reqLog[r0], 32'h100);
    else check("redirect_req_count", 32'(reqLog.size()), 32'(r0 + 1));
    latMin = 1; latMax = 1;
    waitReq();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    @(posedge clk) #1;
    check("flush_stall_valid", 32'(valid_d), 0);
    check("flush_stall_instr", instr_d, NOP);
    repeat (5) cycle(0, 0, 0, 0);
    cycle(0, 1, 32'hFFFF_FFFF, 1);
    repeat (10) cycle(0, 0, 0, 0);
    latMin = 1; latMax = 4;
    repeat (700) begin
      logic src;
      src = ($urandom % 12) == 0;
      cycle(($urandom % 10) < 3, src, $urandom, src & $urandom_range(1, 0));
    end
    latMin = 3; latMax = 3;
    waitReq();
    cycle(0, 0, 0, 0);
    #2 rst = 1;
    #1 checkResetOutputs("async_reset");
    pending = 0; imem_rvalid = 0; stall_d = 0; pc_src = 0; flush_d = 0;
    prevInstr = NOP; prevPc = 0; prevValid = 0; prevStall = 0; prevSrc = 0; prevFlush = 0; prevReq = 0;
    expPc = 0;
    @(negedge clk);
    @(negedge clk) rst = 0;
    r0 = reqLog.size();
    latMin = 1; latMax = 1;
    repeat (8) cycle(0, 0, 0, 0);
    if (reqLog.size() > r0) check("post_reset_addr", reqLog[r0], 0);
    else check("post_reset_req_count", 32'(reqLog.size()), 32'(r0 + 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
